// File: rtl/uart_cfg_pkg.sv
// Shared constants and FSM state encodings for the configurable UART.
package uart_cfg_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [4:0] TickMid   = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] TickLast  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] TickLast2 = 5'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  // Last tick index of the whole stop period on the TX side.
  function automatic logic [4:0] stop_last(input logic two_stop);
    return two_stop ? TickLast2 : TickLast;
  endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// First-word-fall-through FIFO, 2^AW words deep; memory is not cleared by reset.
module uart_cfg_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  output logic          empty,
  output logic          full,
  output logic [DW-1:0] r_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          wr_en, rd_en;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A read frees a slot in the same cycle, so a write while full still lands.
  assign wr_en  = wr && (!full || rd);
  assign rd_en  = rd && !empty;
  assign r_data = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q[AW-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// UART with runtime baud divisor, optional parity and 1/2 stop bits;
// 16x oversampled RX and TX, each backed by a FWFT FIFO.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned FIFO_W = 4,
  parameter int unsigned DVSR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rd_uart,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic              clr_err,
  output logic              tx,
  output logic              tx_full,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [DBIT-1:0]   r_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err
);

  // Baud tick generator
  logic [DVSR_W-1:0] cnt_q, dvsr_eff;
  logic              tick;

  assign dvsr_eff = (dvsr == '0) ? DVSR_W'(1) : dvsr;
  assign tick     = (cnt_q == dvsr_eff - DVSR_W'(1));

  // Using >= lets a shrinking divisor wrap the counter immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q >= dvsr_eff - DVSR_W'(1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DVSR_W'(1);
    end
  end

  // Receiver
  rx_state_e       rx_state_q;
  logic [1:0]      rx_sync_q;
  logic            rx_in;
  logic [4:0]      rx_s_q;
  logic [2:0]      rx_n_q;
  logic [DBIT-1:0] rx_b_q, rx_word_q;
  logic            rx_pbit_q, rx_pen_q, rx_odd_q, rx_stop2_q;
  logic            rx_second_q, rx_stop_bad_q;
  logic            rx_push_q, rx_perr_q, rx_ferr_q;

  assign rx_in = rx_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q     <= 2'b11;
      rx_state_q    <= RxIdle;
      rx_s_q        <= '0;
      rx_n_q        <= '0;
      rx_b_q        <= '0;
      rx_word_q     <= '0;
      rx_pbit_q     <= 1'b0;
      rx_pen_q      <= 1'b0;
      rx_odd_q      <= 1'b0;
      rx_stop2_q    <= 1'b0;
      rx_second_q   <= 1'b0;
      rx_stop_bad_q <= 1'b0;
      rx_push_q     <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_push_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_in) begin
            rx_state_q  <= RxStart;
            rx_s_q      <= '0;
            rx_pen_q    <= parity_en;
            rx_odd_q    <= parity_odd;
            rx_stop2_q  <= stop2;
            rx_second_q <= 1'b0;
          end
        end
        RxStart: begin
          if (tick) begin
            if (rx_s_q == TickMid) begin
              if (rx_in) begin
                rx_state_q <= RxIdle;
              end else begin
                rx_state_q <= RxData;
                rx_s_q     <= '0;
                rx_n_q     <= '0;
              end
            end else begin
              rx_s_q <= rx_s_q + 5'd1;
            end
          end
        end
        RxData: begin
          if (tick) begin
            if (rx_s_q == TickLast) begin
              rx_s_q <= '0;
              rx_b_q <= {rx_in, rx_b_q[DBIT-1:1]};
              if (rx_n_q == 3'(DBIT - 1)) begin
                rx_state_q <= rx_pen_q ? RxParity : RxStop;
              end else begin
                rx_n_q <= rx_n_q + 3'd1;
              end
            end else begin
              rx_s_q <= rx_s_q + 5'd1;
            end
          end
        end
        RxParity: begin
          if (tick) begin
            if (rx_s_q == TickLast) begin
              rx_s_q     <= '0;
              rx_pbit_q  <= rx_in;
              rx_state_q <= RxStop;
            end else begin
              rx_s_q <= rx_s_q + 5'd1;
            end
          end
        end
        RxStop: begin
          if (tick) begin
            if (rx_s_q == TickLast) begin
              // Only the first stop bit is checked; the second one is just waited out.
              if (rx_stop2_q && !rx_second_q) begin
                rx_second_q   <= 1'b1;
                rx_s_q        <= '0;
                rx_stop_bad_q <= !rx_in;
              end else begin
                rx_state_q <= RxIdle;
                rx_push_q  <= 1'b1;
                rx_word_q  <= rx_b_q;
                rx_perr_q  <= rx_pen_q & (^rx_b_q ^ rx_pbit_q ^ rx_odd_q);
                rx_ferr_q  <= rx_second_q ? rx_stop_bad_q : !rx_in;
              end
            end else begin
              rx_s_q <= rx_s_q + 5'd1;
            end
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= (parity_err & ~clr_err) | (rx_push_q & rx_perr_q);
      frame_err   <= (frame_err & ~clr_err) | (rx_push_q & rx_ferr_q);
      overrun_err <= (overrun_err & ~clr_err) | (rx_push_q & rx_full & ~rd_uart);
    end
  end

  uart_cfg_fifo #(
    .DW(DBIT),
    .AW(FIFO_W)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .rd    (rd_uart),
    .wr    (rx_push_q),
    .w_data(rx_word_q),
    .empty (rx_empty),
    .full  (rx_full),
    .r_data(r_data)
  );

  // Transmitter
  tx_state_e       tx_state_q;
  logic [4:0]      tx_s_q;
  logic [2:0]      tx_n_q;
  logic [DBIT-1:0] tx_b_q, tx_head;
  logic            tx_par_q, tx_pen_q, tx_stop2_q;
  logic            tx_empty, tx_pop;

  // Pop is combinational so the FIFO is already advanced when TX re-enters idle.
  assign tx_pop = (tx_state_q == TxStop) && tick && (tx_s_q == stop_last(tx_stop2_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx           <= 1'b1;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          tx <= 1'b1;
          if (!tx_empty) begin
            tx_state_q <= TxStart;
            tx         <= 1'b0;
            tx_s_q     <= '0;
            tx_b_q     <= tx_head;
            tx_par_q   <= ^tx_head ^ parity_odd;
            tx_pen_q   <= parity_en;
            tx_stop2_q <= stop2;
          end
        end
        TxStart: begin
          if (tick) begin
            if (tx_s_q == TickLast) begin
              tx_state_q <= TxData;
              tx_s_q     <= '0;
              tx_n_q     <= '0;
              tx         <= tx_b_q[0];
            end else begin
              tx_s_q <= tx_s_q + 5'd1;
            end
          end
        end
        TxData: begin
          if (tick) begin
            if (tx_s_q == TickLast) begin
              tx_s_q <= '0;
              if (tx_n_q == 3'(DBIT - 1)) begin
                tx_state_q <= tx_pen_q ? TxParity : TxStop;
                tx         <= tx_pen_q ? tx_par_q : 1'b1;
              end else begin
                tx_n_q <= tx_n_q + 3'd1;
                tx_b_q <= {1'b0, tx_b_q[DBIT-1:1]};
                tx     <= tx_b_q[1];
              end
            end else begin
              tx_s_q <= tx_s_q + 5'd1;
            end
          end
        end
        TxParity: begin
          if (tick) begin
            if (tx_s_q == TickLast) begin
              tx_s_q     <= '0;
              tx_state_q <= TxStop;
              tx         <= 1'b1;
            end else begin
              tx_s_q <= tx_s_q + 5'd1;
            end
          end
        end
        TxStop: begin
          if (tick) begin
            if (tx_pop) begin
              tx_state_q <= TxIdle;
            end else begin
              tx_s_q <= tx_s_q + 5'd1;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  uart_cfg_fifo #(
    .DW(DBIT),
    .AW(FIFO_W)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .rd    (tx_pop),
    .wr    (wr_uart),
    .w_data(w_data),
    .empty (tx_empty),
    .full  (tx_full),
    .r_data(tx_head)
  );

endmodule

// File: tb/tb_uart_cfg.sv
// Directed scoreboard bench for uart_cfg: loopback, parity/frame/overrun errors,
// start-bit glitch rejection and reset in the middle of a TX frame.
module tb_uart_cfg;

  localparam int DBIT    = 8;
  localparam int FIFO_W  = 2;
  localparam int DVSR_W  = 16;
  localparam int BIT_CLK = 32;  // dvsr=2, 16 ticks per bit

  logic              clk = 1'b0;
  logic              reset;
  logic              rx, rx_drv, loop;
  logic              rd_uart, wr_uart;
  logic [DBIT-1:0]   w_data;
  logic [DVSR_W-1:0] dvsr;
  logic              parity_en, parity_odd, stop2, clr_err;
  logic              tx, tx_full, rx_empty, rx_full;
  logic [DBIT-1:0]   r_data;
  logic              parity_err, frame_err, overrun_err;

  int checks = 0;
  int errors = 0;
  logic [DBIT-1:0] exp_q[$];

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cfg #(
    .DBIT  (DBIT),
    .FIFO_W(FIFO_W),
    .DVSR_W(DVSR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_uart    (rd_uart),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .dvsr       (dvsr),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .clr_err    (clr_err),
    .tx         (tx),
    .tx_full    (tx_full),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .r_data     (r_data),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int budget, output bit ok, output int waited);
    waited = 0;
    while (rx_empty && waited < budget) begin
      cyc(1);
      waited++;
    end
    ok = !rx_empty;
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    cyc(1);
    rd_uart = 1'b0;
  endtask

  task automatic send_frame(input logic [DBIT-1:0] d, input bit pen, input bit pbit,
                            input bit stopv, input int stop_clks);
    rx_drv = 1'b0;
    cyc(BIT_CLK);
    for (int i = 0; i < DBIT; i++) begin
      rx_drv = d[i];
      cyc(BIT_CLK);
    end
    if (pen) begin
      rx_drv = pbit;
      cyc(BIT_CLK);
    end
    rx_drv = stopv;
    cyc(stop_clks);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    loop = 1'b0; rx_drv = 1'b1; rd_uart = 1'b0; wr_uart = 1'b0; w_data = '0;
    dvsr = 16'd2; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; clr_err = 1'b0;
    cyc(5);
    reset = 1'b0;
    cyc(2);
    checks++;
    if ({tx, tx_full, rx_empty, rx_full} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_status: tx/tx_full/rx_empty/rx_full got %b want 1010",
               {tx, tx_full, rx_empty, rx_full});
    end
    checks++;
    if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overrun_err});
    end
  endtask

  task automatic test_loopback();
    bit ok;
    int waited;
    logic [DBIT-1:0] e;
    loop = 1'b1;
    cyc(2);
    w_data = 8'hA5; wr_uart = 1'b1;
    exp_q.push_back(8'hA5);
    cyc(1);
    wr_uart = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL latency_n1: tx got %b want 1", tx);
    end
    cyc(1);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL latency_n2: tx got %b want 0", tx);
    end
    wait_rx(1000, ok, waited);
    checks++;
    if (!ok || waited < 280 || waited > 340) begin
      errors++;
      $display("FAIL loopback_arrival: ok=%0d after %0d clk, want ~320", ok, waited);
    end
    e = exp_q.pop_front();
    checks++;
    if (r_data !== e) begin
      errors++;
      $display("FAIL loopback_data: got %h want %h", r_data, e);
    end
    checks++;
    if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
      errors++;
      $display("FAIL loopback_flags: got %b want 000", {parity_err, frame_err, overrun_err});
    end
    pop_rx();
    cyc(40);
    loop = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int waited;
    logic [DBIT-1:0] e;
    loop = 1'b1;
    parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    w_data = 8'h3C; wr_uart = 1'b1; exp_q.push_back(8'h3C);
    cyc(1);
    w_data = 8'hC3; exp_q.push_back(8'hC3);
    cyc(1);
    wr_uart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_rx(1200, ok, waited);
      e = exp_q.pop_front();
      checks++;
      if (!ok || r_data !== e) begin
        errors++;
        $display("FAIL b2b_word%0d: ok=%0d got %h want %h", k, ok, r_data, e);
      end
      pop_rx();
    end
    checks++;
    if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_flags: got %b want 000", {parity_err, frame_err, overrun_err});
    end
    cyc(100);
    loop = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
  endtask

  task automatic test_parity();
    bit ok;
    int waited;
    logic [DBIT-1:0] e;
    parity_en = 1'b1; parity_odd = 1'b0;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, BIT_CLK);
    wait_rx(100, ok, waited);
    e = exp_q.pop_front();
    checks++;
    if (!ok || r_data !== e) begin
      errors++;
      $display("FAIL parity_data: ok=%0d got %h want %h", ok, r_data, e);
    end
    checks++;
    if ({parity_err, frame_err} !== 2'b10) begin
      errors++;
      $display("FAIL parity_flag: parity/frame got %b want 10", {parity_err, frame_err});
    end
    pop_rx();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: got %b want 0", parity_err);
    end
    parity_en = 1'b0;
    cyc(20);
  endtask

  task automatic test_frame_err();
    bit ok;
    int waited;
    logic [DBIT-1:0] e;
    exp_q.push_back(8'h5A);
    // Short low stop bit: the re-triggered start after it is rejected as a glitch.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 24);
    wait_rx(100, ok, waited);
    e = exp_q.pop_front();
    checks++;
    if (!ok || r_data !== e) begin
      errors++;
      $display("FAIL frame_data: ok=%0d got %h want %h", ok, r_data, e);
    end
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_flag: got %b want 1", frame_err);
    end
    pop_rx();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear: got %b want 0", frame_err);
    end
    cyc(60);
  endtask

  task automatic test_glitch();
    rx_drv = 1'b0;
    cyc(8);
    rx_drv = 1'b1;
    cyc(60);
    checks++;
    if (rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL glitch_empty: rx_empty got %b want 1", rx_empty);
    end
    checks++;
    if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
      errors++;
      $display("FAIL glitch_flags: got %b want 000", {parity_err, frame_err, overrun_err});
    end
  endtask

  task automatic test_overrun();
    logic [DBIT-1:0] e;
    for (int k = 1; k <= 5; k++) begin
      if (k <= (1 << FIFO_W)) exp_q.push_back(DBIT'(k));
      send_frame(DBIT'(k), 1'b0, 1'b0, 1'b1, BIT_CLK);
    end
    cyc(10);
    checks++;
    if (rx_full !== 1'b1) begin
      errors++;
      $display("FAIL overrun_full: rx_full got %b want 1", rx_full);
    end
    checks++;
    if (overrun_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b want 1", overrun_err);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_empty !== 1'b0 || r_data !== e) begin
        errors++;
        $display("FAIL overrun_read: empty=%b got %h want %h", rx_empty, r_data, e);
      end
      pop_rx();
    end
    checks++;
    if (rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drain: rx_empty got %b want 1", rx_empty);
    end
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    int lows;
    w_data = 8'hA5; wr_uart = 1'b1;
    cyc(1);
    wr_uart = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      cyc(1);
      n++;
    end
    cyc(BIT_CLK * 4 + 16);  // middle of data bit 3 (0 for 0xA5)
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bit3: tx got %b want 0", tx);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_full !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: tx/tx_full got %b%b want 10", tx, tx_full);
    end
    cyc(2);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_quiet: tx low for %0d clk (want 0), rx_empty %b want 1",
               lows, rx_empty);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame; legal range 5..8.
REQ-002 Parameter FIFO_W, default 4: address bits per FIFO; depth is 2^FIFO_W words.
REQ-003 Parameter DVSR_W, default 16: width of the runtime baud divisor.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rx  in  1  serial input, idle high.
REQ-008 rd_uart  in  1  pop one RX word.
REQ-009 wr_uart  in  1  push w_data into the TX FIFO.
REQ-010 w_data  in  DBIT  TX word.
REQ-011 dvsr  in  DVSR_W  clk cycles per 16x oversample tick.
REQ-012 parity_en  in  1  enables the parity bit.
REQ-013 parity_odd  in  1  selects odd parity (1) or even parity (0).
REQ-014 stop2  in  1  selects 2 stop bits (1) or 1 stop bit (0).
REQ-015 clr_err  in  1  clears the sticky error flags.
REQ-016 tx  out  1  serial output.
REQ-017 tx_full  out  1  TX FIFO full.
REQ-018 rx_empty  out  1  RX FIFO empty.
REQ-019 rx_full  out  1  RX FIFO full.
REQ-020 r_data  out  DBIT  RX FIFO head word.
REQ-021 parity_err, frame_err, overrun_err  out  1 each  sticky error flags.

Function
REQ-022 Baud counter SHALL count 0..dvsr-1 and pulse tick for one clk at dvsr-1; dvsr=0 is treated as 1; if count>=dvsr after a dvsr change, the counter SHALL wrap to 0 on the next clk.
REQ-023 Bit period SHALL be 16 ticks.
REQ-024 Frame format SHALL be: start(0), DBIT data bits LSB first, optional parity bit, 1 or 2 stop bits(1).
REQ-025 parity_en, parity_odd and stop2 SHALL be latched separately by RX and TX on leaving idle; changes mid-frame do not affect the current frame.
REQ-026 RX FSM states SHALL be idle, start, data, parity, stop.
REQ-027 RX idle->start on rx=0; after 7 ticks, if rx=1 the FSM SHALL return to idle (glitch, no word); otherwise it SHALL proceed to data.
REQ-028 RX SHALL sample each subsequent bit every 16 ticks (mid-bit); stop is checked on the first stop bit only, and stop2 only extends the wait.
REQ-029 At frame end the RX SHALL push the word if RX FIFO not full, else drop it and set overrun_err; a parity mismatch SHALL set parity_err and the word SHALL still be pushed; stop sample 0 SHALL set frame_err and the word SHALL still be pushed.
REQ-030 Error flags SHALL hold until clr_err; if clr_err and a new error occur in the same cycle, the flag SHALL be set.
REQ-031 TX FSM states SHALL be idle, start, data, parity, stop; it leaves idle whenever TX FIFO not empty; tx SHALL be 1 in idle.
REQ-032 TX SHALL pop the FIFO in the last tick of the stop period and SHALL return to idle for at least 1 clk before the next start.
REQ-033 Latency: wr_uart into an empty TX FIFO in cycle n SHALL drive tx=0 in cycle n+2.
REQ-034 FIFOs SHALL be first-word-fall-through; write when full is ignored; read when empty is ignored; rd+wr when full both take effect; rd+wr when empty performs the write only.
REQ-035 r_data is don't-care while rx_empty=1.

Reset
REQ-036 Reset SHALL asynchronously force: tx=1, tx_full=0, rx_empty=1, rx_full=0, all error flags 0, both FSMs idle, baud counter 0, both FIFOs empty.
REQ-037 Reset mid-frame SHALL abort the frame with no partial word stored; FIFO memory contents are not cleared.

Structure
REQ-038 Package uart_cfg_pkg SHALL hold the RX/TX state encodings and OVERSAMPLE=16.
REQ-039 The existing fifo module SHALL be instantiated twice (RX, TX); the baud counter and both FSMs SHALL be inline; no other sub-modules.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
- Loopback tx->rx, dvsr=2, 8N1, write 0xA5 -> rx_empty falls after ~320 clk, r_data=0xA5, no error flags.
- Even parity, drive 0x03 with parity bit 1 -> parity_err=1, r_data=0x03.
- 8N1, stop bit driven 0 -> frame_err=1; clr_err pulse -> 0.
- FIFO_W=2, five frames 0x01..0x05 unread -> rx_full=1, overrun_err=1, reads return 0x01..0x04.
- rx low for 4 ticks only -> rx_empty stays 1, no flags.
- Reset asserted in TX data bit 3 -> tx=1 immediately, tx_full=0, no further start bit.
